// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: word, byte and indirect (LDI/STI) data-cache accesses.
// Optional request timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int ADDR_W = 16
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              iClk,
  input  logic              iResetN,
  input  logic              iValid,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic              iByteEnable,
  input  logic              iIndirect,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [ADDR_W-1:0] iStoreData,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [ADDR_W-1:0] oMemWdata,
  output logic [1:0]        oMemByteEn,
  input  logic              iMemResp,
  input  logic [ADDR_W-1:0] iMemRdata,
  output logic              oStall,
  output logic              oDone,
  output logic [ADDR_W-1:0] oReadData,
  output logic              oMemError
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PTR  = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;

  logic [1:0]        state;
  logic              ptr_ok;
  logic              mem_read;
  logic              mem_write;
  logic              is_wr;
  logic              is_byte;
  logic              sel_hi;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [1:0]        byte_en;
  logic              op;
  logic              pend;
  logic              abort;
  logic              fin;
  logic [ADDR_W-1:0] wdata_fmt;
  logic [ADDR_W-1:0] load_fmt;

  assign op   = iValid & (iMemRead | iMemWrite);
  assign pend = mem_read | mem_write;
  assign fin  = (state == ACC) & iMemResp;

  assign wdata_fmt = iByteEnable
                   ? {(ADDR_W/8){iStoreData[7:0]}}
                   : iStoreData;

  function automatic logic [1:0] lanes(
    input logic byte_acc,
    input logic hi
  );
    if (!byte_acc) return 2'b11;
    return hi ? 2'b10 : 2'b01;
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W =
    (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // counter sits at zero while no request is out, so it restarts per issue
  always_ff @(posedge iClk) begin
    if (!iResetN || !pend) begin
      cnt <= '0;
    end else if (!iMemResp) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign abort = pend & ~iMemResp
               & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iResetN) begin
      state     <= IDLE;
      ptr_ok    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      is_wr     <= 1'b0;
      is_byte   <= 1'b0;
      sel_hi    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      byte_en   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (op) begin
            is_wr     <= iMemWrite;
            is_byte   <= iByteEnable;
            mem_wdata <= iMemWrite ? wdata_fmt : '0;
            mem_addr  <= {iAddress[ADDR_W-1:1], 1'b0};
            if (iIndirect) begin
              state     <= PTR;
              ptr_ok    <= 1'b0;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              sel_hi    <= 1'b0;
              byte_en   <= 2'b11;
            end else begin
              state     <= ACC;
              mem_read  <= ~iMemWrite;
              mem_write <= iMemWrite;
              sel_hi    <= iAddress[0];
              byte_en   <= lanes(iByteEnable, iAddress[0]);
            end
          end
        end
        PTR: begin
          if (abort) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            byte_en  <= 2'b00;
          end else if (ptr_ok) begin
            state     <= ACC;
            mem_read  <= ~is_wr;
            mem_write <= is_wr;
            byte_en   <= lanes(is_byte, sel_hi);
          end else if (iMemResp) begin
            // one idle cycle on the bus before the final access
            mem_read <= 1'b0;
            mem_addr <= {iMemRdata[ADDR_W-1:1], 1'b0};
            sel_hi   <= 1'b0;
            ptr_ok   <= 1'b1;
          end
        end
        ACC: begin
          if (iMemResp || abort) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            byte_en   <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_fmt = iMemRdata;
    if (is_byte) begin
      load_fmt = '0;
      load_fmt[7:0] = sel_hi ? iMemRdata[15:8] : iMemRdata[7:0];
    end
  end

  assign oMemRead   = mem_read;
  assign oMemWrite  = mem_write;
  assign oMemAddr   = mem_addr;
  assign oMemWdata  = mem_wdata;
  assign oMemByteEn = byte_en;

  assign oStall = iResetN & ~abort
                & ((op & (state == IDLE))
                |  (state == PTR)
                |  ((state == ACC) & ~iMemResp));
  assign oDone     = iResetN & (fin | abort);
  assign oMemError = iResetN & abort;
  assign oReadData = (iResetN & fin & ~is_wr) ? load_fmt : '0;

endmodule
